// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared state encoding, field-width and address-field helpers
//               for the direct-mapped write-through data cache.
// Revision    : 1.0
// ============================================================================
package dcache_pkg;

    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_REFILL = 2'd1;
    localparam state_t S_WRITE  = 2'd2;
    localparam state_t S_DONE   = 2'd3;

    function automatic int offsetWidth(input int wordsPerLine);
        return $clog2(wordsPerLine);
    endfunction

    function automatic int indexWidth(input int sets);
        return $clog2(sets);
    endfunction

    // Everything above the byte offset, word offset and index is tag.
    function automatic int tagWidth(input int sets, input int wordsPerLine);
        return 32 - 2 - offsetWidth(wordsPerLine) - indexWidth(sets);
    endfunction

    function automatic logic [31:0] addrField(input logic [31:0] addr,
                                              input int lsb, input int width);
        return (addr >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_data_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_data_array
// Description : SETS x WORDS_PER_LINE x 32 storage, one synchronous write port
//               and one asynchronous read port. Contents are not reset.
// Revision    : 1.0
// ============================================================================
module dcache_data_array
    import dcache_pkg::*;
#(
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                   clk,
    input  logic                                   i_we,
    input  logic [indexWidth(SETS)-1:0]            i_wIndex,
    input  logic [offsetWidth(WORDS_PER_LINE)-1:0] i_wOffset,
    input  logic [31:0]                            i_wData,
    input  logic [indexWidth(SETS)-1:0]            i_rIndex,
    input  logic [offsetWidth(WORDS_PER_LINE)-1:0] i_rOffset,
    output logic [31:0]                            o_rData
);

    logic [31:0] r_mem [SETS*WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[{i_wIndex, i_wOffset}] <= i_wData;
        end
    end

    assign o_rData = r_mem[{i_rIndex, i_rOffset}];

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Direct-mapped, write-through, read-allocate M-stage data cache
//               with line refill, write-through port and hit/miss statistics.
// Revision    : 1.0
// ============================================================================
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] RD2_Reg_File_aft_muxM,
    output logic [31:0] Mem_RDM,
    output logic        Mem_Stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int c_OFFSET_W  = offsetWidth(WORDS_PER_LINE);
    localparam int c_INDEX_W   = indexWidth(SETS);
    localparam int c_TAG_W     = tagWidth(SETS, WORDS_PER_LINE);
    localparam int c_INDEX_LSB = 2 + c_OFFSET_W;
    localparam int c_TAG_LSB   = c_INDEX_LSB + c_INDEX_W;

    state_t                r_state;
    logic [c_OFFSET_W-1:0] r_cnt;
    logic [SETS-1:0]       r_valid;
    logic [c_TAG_W-1:0]    r_tags [SETS];
    logic [31:0]           r_reqAddr;
    logic [31:0]           r_reqData;
    logic                  r_reqHit;
    logic [31:0]           r_rdataQ;
    logic [31:0]           r_hitCount;
    logic [31:0]           r_missCount;

    logic [c_OFFSET_W-1:0] w_inOffset, w_reqOffset, w_arrOffset;
    logic [c_INDEX_W-1:0]  w_inIndex, w_reqIndex;
    logic [c_TAG_W-1:0]    w_inTag, w_reqTag;
    logic                  w_inHit, w_lastWord, w_arrWe;
    logic [31:0]           w_arrData, w_arrWord;

    assign w_inOffset  = c_OFFSET_W'(addrField(ALUoutM, 2, c_OFFSET_W));
    assign w_inIndex   = c_INDEX_W'(addrField(ALUoutM, c_INDEX_LSB, c_INDEX_W));
    assign w_inTag     = c_TAG_W'(addrField(ALUoutM, c_TAG_LSB, c_TAG_W));
    assign w_reqOffset = c_OFFSET_W'(addrField(r_reqAddr, 2, c_OFFSET_W));
    assign w_reqIndex  = c_INDEX_W'(addrField(r_reqAddr, c_INDEX_LSB, c_INDEX_W));
    assign w_reqTag    = c_TAG_W'(addrField(r_reqAddr, c_TAG_LSB, c_TAG_W));
    assign w_inHit     = r_valid[w_inIndex] && (r_tags[w_inIndex] == w_inTag);
    assign w_lastWord  = (r_cnt == {c_OFFSET_W{1'b1}});

    // Refill words land at the counter slot; store hits patch the request word.
    always_comb begin
        w_arrWe     = 1'b0;
        w_arrOffset = r_cnt;
        w_arrData   = mem_rdata;
        if (r_state == S_REFILL) begin
            w_arrWe = mem_ready;
        end else if (r_state == S_WRITE) begin
            w_arrWe     = mem_ready && r_reqHit;
            w_arrOffset = w_reqOffset;
            w_arrData   = r_reqData;
        end
    end

    dcache_data_array #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_dataArray (
        .clk       (clk),
        .i_we      (w_arrWe),
        .i_wIndex  (w_reqIndex),
        .i_wOffset (w_arrOffset),
        .i_wData   (w_arrData),
        .i_rIndex  (w_inIndex),
        .i_rOffset (w_inOffset),
        .o_rData   (w_arrWord)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_valid     <= '0;
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MemWriteM) begin
                        r_state <= S_WRITE;
                    end else if (MemReadM) begin
                        if (w_inHit) begin
                            r_hitCount <= r_hitCount + 32'd1;
                        end else begin
                            r_missCount          <= r_missCount + 32'd1;
                            r_cnt                <= '0;
                            r_valid[w_inIndex]   <= 1'b0;
                            r_state              <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_ready) begin
                        r_cnt <= r_cnt + c_OFFSET_W'(1);
                        if (w_lastWord) begin
                            r_valid[w_reqIndex] <= 1'b1;
                            r_state             <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Request capture and refill side effects; these arrays are never reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            r_reqAddr <= ALUoutM & ~32'h3;
            r_reqData <= RD2_Reg_File_aft_muxM;
            r_reqHit  <= w_inHit;
        end
        if ((r_state == S_REFILL) && mem_ready) begin
            if (r_cnt == w_reqOffset) begin
                r_rdataQ <= mem_rdata;
            end
            if (w_lastWord) begin
                r_tags[w_reqIndex] <= w_reqTag;
            end
        end
    end

    always_comb begin
        Mem_Stall = 1'b0;
        case (r_state)
            S_IDLE:            Mem_Stall = MemWriteM || (MemReadM && !w_inHit);
            S_REFILL, S_WRITE: Mem_Stall = 1'b1;
            default:           Mem_Stall = 1'b0;
        endcase
    end

    assign Mem_RDM    = (r_state == S_DONE) ? r_rdataQ : w_arrWord;
    assign mem_req    = (r_state == S_REFILL) || (r_state == S_WRITE);
    assign mem_we     = (r_state == S_WRITE);
    assign mem_addr   = (r_state == S_REFILL) ? {r_reqAddr[31:c_INDEX_LSB], r_cnt, 2'b00}
                                              : r_reqAddr;
    assign mem_wdata  = r_reqData;
    assign hit_count  = r_hitCount;
    assign miss_count = r_missCount;

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Self-checking bench: directed vector table, reset-mid-refill
//               sequence and randomized ops against a behavioural cache model.
// Revision    : 1.0
// ============================================================================
module tb_dcache_controller;

    localparam int SETS  = 64;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUoutM, RD2_Reg_File_aft_muxM;
    logic [31:0] Mem_RDM;
    logic        Mem_Stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] hit_count, miss_count;

    dcache_controller #(.SETS(SETS), .WORDS_PER_LINE(WORDS)) dut (
        .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUoutM(ALUoutM), .RD2_Reg_File_aft_muxM(RD2_Reg_File_aft_muxM),
        .Mem_RDM(Mem_RDM), .Mem_Stall(Mem_Stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endfunction

    function automatic logic [31:0] initWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Main-memory responder: ready pulses after memL idle cycles per request.
    logic [31:0] mainMem [logic [31:0]];
    logic [31:0] txAddr[$];
    logic        txWe[$];
    logic [31:0] txData[$];
    int          memL = 2;
    int          waitCnt = 0;

    always @(negedge clk) begin
        if (mem_ready) begin
            mem_ready = 1'b0;
            waitCnt   = 0;
        end
        if (mem_req) begin
            waitCnt++;
            if (waitCnt == memL + 1) begin
                mem_ready = 1'b1;
                txAddr.push_back(mem_addr);
                txWe.push_back(mem_we);
                txData.push_back(mem_wdata);
                if (mem_we) mainMem[mem_addr] = mem_wdata;
                else mem_rdata = mainMem.exists(mem_addr) ? mainMem[mem_addr] : initWord(mem_addr);
            end
        end else begin
            waitCnt = 0;
        end
    end

    // Reference model: which line each set holds, memory image, stat counters.
    bit          mValid [SETS];
    logic [31:0] mLine  [SETS];
    logic [31:0] refMem [logic [31:0]];
    logic [31:0] mHits = 0, mMisses = 0;

    function automatic logic [31:0] refWord(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initWord(a);
    endfunction

    task automatic modelReset();
        for (int s = 0; s < SETS; s++) mValid[s] = 1'b0;
        mHits = 0;
        mMisses = 0;
    endtask

    task automatic doOp(input string nm, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit useModel, input int tblStall, input logic [31:0] tblData);
        logic [31:0] line, wa, got, expData;
        int          set, stalls, expStall, expN;
        bit          isLoad, hit, done;
        isLoad = rd && !wr;
        wa     = addr & ~32'h3;
        line   = addr >> 4;
        set    = int'(line % SETS);
        hit    = mValid[set] && (mLine[set] == line);
        if (isLoad) expStall = hit ? 0 : WORDS * (memL + 1) + 1;
        else if (wr) expStall = memL + 2;
        else expStall = 0;
        expN = (isLoad && !hit) ? WORDS : (wr ? 1 : 0);
        if (wr) refMem[wa] = wdata;
        expData = refWord(wa);
        if (isLoad) begin
            if (hit) mHits++;
            else begin
                mMisses++;
                mValid[set] = 1'b1;
                mLine[set]  = line;
            end
        end
        if (!useModel) begin
            expStall = tblStall;
            expData  = tblData;
        end
        txAddr.delete(); txWe.delete(); txData.delete();
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; ALUoutM = addr; RD2_Reg_File_aft_muxM = wdata;
        stalls = 0; done = 0; got = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            #1;
            if (!Mem_Stall) begin
                got  = Mem_RDM;
                done = 1;
            end else begin
                stalls++;
                @(negedge clk);
            end
        end
        check({nm, "_timeout"}, 32'(done), 32'd1);
        check({nm, "_stall"}, 32'(stalls), 32'(expStall));
        if (isLoad) check({nm, "_rdata"}, got, expData);
        @(posedge clk);
        #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
        check({nm, "_hits"}, hit_count, mHits);
        check({nm, "_misses"}, miss_count, mMisses);
        check({nm, "_txcount"}, 32'(txAddr.size()), 32'(expN));
        if (txAddr.size() == expN) begin
            for (int k = 0; k < expN; k++) begin
                if (wr) begin
                    check({nm, "_waddr"}, txAddr[k], wa);
                    check({nm, "_wdata"}, txData[k], wdata);
                    check({nm, "_we"}, 32'(txWe[k]), 32'd1);
                end else begin
                    check({nm, "_raddr"}, txAddr[k], (wa & ~32'hF) + 32'(4 * k));
                    check({nm, "_re"}, 32'(txWe[k]), 32'd0);
                end
            end
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          expStall;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,          13, initWord(32'h104)};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_010C, 32'h0,          0,  initWord(32'h10C)};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0108, 32'hDEAD_BEEF,  4,  32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,          0,  32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_4000, 32'hCAFE_F00D,  4,  32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,          13, 32'hCAFE_F00D};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,          0,  initWord(32'h104)};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_1104, 32'h0,          13, initWord(32'h1104)};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0106, 32'h0,          13, initWord(32'h104)};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0104, 32'h1111_2222,  4,  32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,          0,  32'h1111_2222};

        rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; ALUoutM = '0; RD2_Reg_File_aft_muxM = '0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", 32'(Mem_Stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);

        memL = 2;
        for (int i = 0; i < 11; i++) begin
            doOp($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                 vecs[i].wdata, 1'b0, vecs[i].expStall, vecs[i].expData);
        end

        // Reset after two of four refill words: request drops, line stays invalid.
        txAddr.delete(); txWe.delete(); txData.delete();
        @(negedge clk);
        MemReadM = 1'b1; ALUoutM = 32'h0000_2204;
        begin
            int c;
            for (c = 0; c < 200 && txAddr.size() < 2; c++) @(posedge clk);
            check("midrst_wait", 32'(txAddr.size()), 32'd2);
        end
        @(negedge clk);
        rst = 1'b1; MemReadM = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_stall", 32'(Mem_Stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        #1;
        check("midrst_misses", miss_count, 32'd0);
        doOp("midrst_reload", 1'b1, 1'b0, 32'h0000_2204, 32'h0, 1'b1, 0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int          kind;
            memL = $urandom_range(0, 3);
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3)) |
                (32'($urandom_range(0, 1)) << 31);
            kind = $urandom_range(0, 99);
            if (kind < 50)      doOp("rnd_ld", 1'b1, 1'b0, a, 32'h0, 1'b1, 0, 32'h0);
            else if (kind < 85) doOp("rnd_st", 1'b0, 1'b1, a, $urandom, 1'b1, 0, 32'h0);
            else if (kind < 95) doOp("rnd_idle", 1'b0, 1'b0, a, 32'h0, 1'b1, 0, 32'h0);
            else                doOp("rnd_both", 1'b1, 1'b1, a, $urandom, 1'b1, 0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-through, read-allocate data-cache controller serving the pipeline's M stage. It decodes M-stage load/store requests, answers load hits in the same cycle, and otherwise drives `Mem_Stall` to freeze every pipeline register. While the pipeline is frozen it runs line refills or write-through transactions on a simple request/ready main-memory port. It owns the tag/valid state and the data array, and keeps read hit/miss statistics.

## Interface
Parameters:
- `SETS`, 64: number of lines; power of two.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `MemReadM`  in  1  load in M stage.
- `MemWriteM`  in  1  store in M stage.
- `ALUoutM`  in  32  byte address; bits [1:0] ignored.
- `RD2_Reg_File_aft_muxM`  in  32  store data.
- `Mem_RDM`  out  32  load data to the M/W register.
- `Mem_Stall`  out  1  freeze all pipeline registers.
- `mem_req`  out  1  main-memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  32  word-aligned main-memory address.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data, valid with `mem_ready`.
- `mem_ready`  in  1  one-cycle completion pulse for the current request.
- `hit_count`  out  32  read hits; wraps modulo 2^32.
- `miss_count`  out  32  read misses; wraps modulo 2^32.

## Operation
Address split:
- Bits [1:0]: byte offset, ignored.
- Next OFFSET_W = log2(WORDS_PER_LINE) bits: word offset.
- Next INDEX_W = log2(SETS) bits: index.
- Remaining bits: tag (22 bits at defaults).

States: IDLE, REFILL, WRITE, DONE.

IDLE:
- Read hit (valid[index] and tag match): `Mem_RDM` = array word, `Mem_Stall`=0, `hit_count`+1. State stays IDLE.
- Read miss: `Mem_Stall`=1, `miss_count`+1, word counter cleared, next state REFILL.
- Write (hit or miss): `Mem_Stall`=1, next state WRITE.
- `MemReadM` and `MemWriteM` both high is illegal; the controller treats it as a write.

REFILL:
- `mem_req`=1, `mem_we`=0, `mem_addr`={tag, index, cnt, 2'b00}.
- On each `mem_ready`: `mem_rdata` is written to array[index][cnt]. If cnt equals the request's word offset, the word is also captured in `rdata_q`. Then cnt increments.
- After the last word: valid[index]=1, tag[index] = request tag, next state DONE.

WRITE:
- `mem_req`=1, `mem_we`=1, `mem_addr` = request address with [1:0] cleared, `mem_wdata` = store data.
- On `mem_ready`: if the store hit, the array word is updated (no allocate on miss). Next state DONE.

DONE:
- `Mem_Stall`=0, `Mem_RDM` = `rdata_q` (don't-care after a write). Next state IDLE unconditionally.
- The request completes here, and the pipeline advances on this edge.

In every state except IDLE and DONE, `Mem_Stall`=1.

## Timing
- Reset values: state IDLE, all valid bits 0, cnt 0, `hit_count`=`miss_count`=0, `mem_req`=0, `mem_we`=0, `Mem_Stall`=0 (no request). Tag and data arrays are not reset.
- Load hit: zero added latency. `Mem_RDM` and `Mem_Stall` are combinational from the M-stage inputs.
- Load miss with memory latency L per word: the instruction holds M for WORDS_PER_LINE×(L+1) + 2 cycles.
- Store: L+3 cycles, including IDLE and DONE.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable from request until the cycle `mem_ready` is sampled. The controller never deasserts `mem_req` early, except on `rst`.
- `mem_ready` outside REFILL or WRITE is ignored.
- Request inputs are frozen while `Mem_Stall`=1. The controller samples them only in IDLE.
- Reset mid-refill: `rst` forces IDLE next cycle and `mem_req` drops. The partially filled line stays invalid, because valid is set only after the last word.
- Back-to-back memory ops: DONE→IDLE gives exactly one hit-capable cycle for the next instruction.

## Structure
- Package `dcache_pkg`:
  - state enum (IDLE, REFILL, WRITE, DONE);
  - functions deriving OFFSET_W, INDEX_W and TAG_W from the parameters;
  - address-field extraction helpers.
- Sub-module `dcache_data_array`:
  - SETS×WORDS_PER_LINE×32 storage, one synchronous write port, one asynchronous read port.
- The tag and valid arrays, FSM, counters and memory-port drive live in `dcache_controller`.

## Test plan
- **Reset / cold read.** Apply `rst`, then load 0x0000_0104 with L=2. Expect:
  - `Mem_Stall` high for 4×3+1 cycles;
  - reads at 0x100, 0x104, 0x108, 0x10C;
  - DONE returns the 0x104 word;
  - `miss_count`=1.
- **Hit after fill.** Load 0x0000_010C next. Expect:
  - `Mem_Stall`=0;
  - word returned the same cycle;
  - `hit_count`=1.
- **Store hit.** Store 0xDEAD_BEEF to 0x108. Expect:
  - one memory write at 0x108, stall until `mem_ready`;
  - a following load of 0x108 hits and returns 0xDEAD_BEEF.
- **Store miss.** Store to 0x0000_4000, set 0 not cached. Expect:
  - memory write only;
  - a subsequent load of 0x4000 misses (no allocate).
- **Conflict.** Load 0x104, then 0x1104 (same index, different tag). Expect:
  - the second load misses and refills;
  - reloading 0x104 misses again.
- **Reset mid-refill.** Assert `rst` after 2 of 4 refill words. Expect:
  - `mem_req`=0 next cycle;
  - a reload of the same address misses.
